// File: rtl/maze_pkg.sv
// Shared types for the maze memory arbiter slice.
// Coordinate width defaults, FSM states and requester ids.
package maze_pkg;

  localparam int X_W_DEF = 4;
  localparam int Y_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    CLEAR
  } state_t;

  typedef enum logic {
    HOST,
    SOLVER
  } owner_t;

endpackage

// File: rtl/maze_clear_sweeper.sv
// Clear engine: walks every maze cell once, x fastest, one write per cycle.
// Ports: clk, rst (sync, high), i_start -> o_busy, o_x, o_y, o_wr, o_done.
module maze_clear_sweeper
  import maze_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  output logic           o_busy,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_wr,
  output logic           o_done
);

  localparam int CW = X_W + Y_W;

  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          w_last;

  assign w_last = r_busy & (&r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (r_busy) begin
        // wraps back to zero after the last cell
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_busy <= 1'b0;
        end
      end else if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_wr   = r_busy;
  assign o_x    = r_cnt[X_W-1:0];
  assign o_y    = r_cnt[CW-1:X_W];
  assign o_done = r_done;

endmodule

// File: rtl/maze_mem_arbiter.sv
// Round-robin, burst-limited arbiter for the single-port maze memory.
// Ports: host/solver req+ack channels, clr_start/busy/done, mem_* bus.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int   X_W       = X_W_DEF,
  parameter int   Y_W       = Y_W_DEF,
  parameter int   MAX_BURST = 4,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hst_req,
  input  logic           hst_we,
  input  logic [X_W-1:0] hst_x,
  input  logic [Y_W-1:0] hst_y,
  input  logic           hst_din,
  output logic           hst_ack,
  output logic           hst_rdata,
  input  logic           slv_req,
  input  logic           slv_we,
  input  logic [X_W-1:0] slv_x,
  input  logic [Y_W-1:0] slv_y,
  input  logic           slv_din,
  output logic           slv_ack,
  output logic           slv_rdata,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic           clr_done,
  output logic [X_W-1:0] mem_x,
  output logic [Y_W-1:0] mem_y,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           mem_din,
  input  logic           mem_dout
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MB = BW'(MAX_BURST);

  state_t         r_state;
  state_t         w_nxt;
  owner_t         r_owner;
  owner_t         r_last;
  owner_t         w_win;
  owner_t         w_other;
  logic [BW-1:0]  r_burst;
  logic           r_we;
  logic           r_din;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_pend;

  logic           w_clr_go;
  logic           w_grant;
  logic           w_both;
  logic           w_keep;

  logic           w_sw_busy;
  logic [X_W-1:0] w_sw_x;
  logic [Y_W-1:0] w_sw_y;
  logic           w_sw_wr;
  logic           w_sw_done;
  logic           w_sw_last;

  maze_clear_sweeper #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_clr_go),
    .o_busy  (w_sw_busy),
    .o_x     (w_sw_x),
    .o_y     (w_sw_y),
    .o_wr    (w_sw_wr),
    .o_done  (w_sw_done)
  );

  assign w_sw_last = w_sw_busy & (&w_sw_x) & (&w_sw_y);

  // clear beats any pending request when idle
  assign w_clr_go = (r_state == IDLE) & (r_pend | clr_start);
  assign w_grant  = (r_state == IDLE) & ~(r_pend | clr_start)
                  & (hst_req | slv_req);

  assign w_both  = hst_req & slv_req;
  assign w_keep  = r_burst < MB;
  assign w_other = (r_last == HOST) ? SOLVER : HOST;

  always_comb begin
    w_win = HOST;
    unique case (1'b1)
      w_both:              w_win = w_keep ? r_last : w_other;
      hst_req & ~slv_req:  w_win = HOST;
      slv_req & ~hst_req:  w_win = SOLVER;
      default:             w_win = HOST;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_clr_go) begin
          w_nxt = CLEAR;
        end else if (w_grant) begin
          w_nxt = ACCESS;
        end
      end
      ACCESS: w_nxt = RESP;
      RESP:   w_nxt = IDLE;
      CLEAR: begin
        if (w_sw_last) begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= HOST;
      r_last  <= HOST;
      r_burst <= '0;
      r_we    <= 1'b0;
      r_din   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // a start seen mid-sweep is absorbed
      if (w_clr_go) begin
        r_pend <= 1'b0;
      end else if (clr_start && r_state != CLEAR) begin
        r_pend <= 1'b1;
      end
      if (w_grant) begin
        r_owner <= w_win;
        if (w_win == HOST) begin
          r_we  <= hst_we;
          r_din <= hst_din;
          r_x   <= hst_x;
          r_y   <= hst_y;
        end else begin
          r_we  <= slv_we;
          r_din <= slv_din;
          r_x   <= slv_x;
          r_y   <= slv_y;
        end
        if (w_win == r_last) begin
          if (r_burst != MB) begin
            r_burst <= r_burst + BW'(1);
          end
        end else begin
          r_last  <= w_win;
          r_burst <= BW'(1);
        end
      end
    end
  end

  always_comb begin
    hst_ack   = 1'b0;
    hst_rdata = 1'b0;
    slv_ack   = 1'b0;
    slv_rdata = 1'b0;
    mem_x     = '0;
    mem_y     = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_din   = 1'b0;
    unique case (r_state)
      IDLE: begin
      end
      ACCESS: begin
        mem_x   = r_x;
        mem_y   = r_y;
        mem_wr  = r_we;
        mem_rd  = ~r_we;
        mem_din = r_din;
      end
      RESP: begin
        if (r_owner == HOST) begin
          hst_ack   = 1'b1;
          hst_rdata = ~r_we & mem_dout;
        end else begin
          slv_ack   = 1'b1;
          slv_rdata = ~r_we & mem_dout;
        end
      end
      CLEAR: begin
        mem_x   = w_sw_x;
        mem_y   = w_sw_y;
        mem_wr  = w_sw_wr;
        mem_din = CLEAR_VAL;
      end
      default: begin
      end
    endcase
  end

  assign clr_busy = r_pend | (r_state == CLEAR);
  assign clr_done = w_sw_done;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a scoreboard queue.
// Holds a behavioural cell memory and a shadow copy for expected reads.
module tb_maze_mem_arbiter;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hst_req = 0, hst_we = 0, hst_din = 0;
  logic [3:0] hst_x = 0, hst_y = 0;
  logic       slv_req = 0, slv_we = 0, slv_din = 0;
  logic [3:0] slv_x = 0, slv_y = 0;
  logic       clr_start = 0;
  logic       hst_ack, hst_rdata, slv_ack, slv_rdata;
  logic       clr_busy, clr_done;
  logic [3:0] mem_x, mem_y;
  logic       mem_rd, mem_wr, mem_din;
  logic       mem_dout = 1'b0;

  always #5 clk = ~clk;

  maze_mem_arbiter #(
    .X_W(4), .Y_W(4), .MAX_BURST(4), .CLEAR_VAL(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .hst_req(hst_req), .hst_we(hst_we), .hst_x(hst_x),
    .hst_y(hst_y), .hst_din(hst_din),
    .hst_ack(hst_ack), .hst_rdata(hst_rdata),
    .slv_req(slv_req), .slv_we(slv_we), .slv_x(slv_x),
    .slv_y(slv_y), .slv_din(slv_din),
    .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  bit tb_mem [256];
  bit sh_mem [256];

  always @(posedge clk) begin
    if (mem_wr) tb_mem[{mem_y, mem_x}] <= mem_din;
    mem_dout <= mem_rd ? tb_mem[{mem_y, mem_x}] : 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       own;
    logic       we;
    logic [3:0] x;
    logic [3:0] y;
    logic       din;
    logic       rd;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic own, input logic v, input logic we,
                     input logic [3:0] x, input logic [3:0] y,
                     input logic din);
    if (!own) begin
      hst_req = v; hst_we = we; hst_x = x; hst_y = y; hst_din = din;
    end else begin
      slv_req = v; slv_we = we; slv_x = x; slv_y = y; slv_din = din;
    end
  endtask

  task automatic push(input logic own, input logic we,
                      input logic [3:0] x, input logic [3:0] y,
                      input logic din);
    exp_t e;
    e.own = own; e.we = we; e.x = x; e.y = y; e.din = din;
    e.rd  = we ? 1'b0 : sh_mem[{y, x}];
    if (we) sh_mem[{y, x}] = din;
    q.push_back(e);
  endtask

  task automatic wait_mem(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(mem_rd | mem_wr) && n < budget);
    chk({tag, "_wait"}, {31'b0, mem_rd | mem_wr}, 1);
  endtask

  task automatic chk_access(input string tag);
    if (q.size() == 0) begin
      chk({tag, "_qempty"}, 0, 1);
      cur = '0;
    end else begin
      cur = q.pop_front();
    end
    chk({tag, "_x"}, {28'b0, mem_x}, {28'b0, cur.x});
    chk({tag, "_y"}, {28'b0, mem_y}, {28'b0, cur.y});
    chk({tag, "_wr"}, {31'b0, mem_wr}, {31'b0, cur.we});
    chk({tag, "_rd"}, {31'b0, mem_rd}, {31'b0, ~cur.we});
    if (cur.we) chk({tag, "_din"}, {31'b0, mem_din}, {31'b0, cur.din});
  endtask

  task automatic chk_resp(input string tag);
    logic ho;
    ho = (cur.own == 1'b0);
    chk({tag, "_hack"}, {31'b0, hst_ack}, {31'b0, ho});
    chk({tag, "_sack"}, {31'b0, slv_ack}, {31'b0, ~ho});
    chk({tag, "_hrd"}, {31'b0, hst_rdata}, {31'b0, ho & cur.rd});
    chk({tag, "_srd"}, {31'b0, slv_rdata}, {31'b0, ~ho & cur.rd});
  endtask

  task automatic single(input string tag, input logic own,
                        input logic we, input logic [3:0] x,
                        input logic [3:0] y, input logic din);
    push(own, we, x, y, din);
    drv(own, 1'b1, we, x, y, din);
    wait_mem(tag, 1);
    chk_access(tag);
    tick();
    chk_resp(tag);
    drv(own, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
  endtask

  initial begin
    int last_ack;
    int errs;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_hack", {31'b0, hst_ack}, 0);
    chk("rst_sack", {31'b0, slv_ack}, 0);
    chk("rst_hrd", {31'b0, hst_rdata}, 0);
    chk("rst_srd", {31'b0, slv_rdata}, 0);
    chk("rst_memrd", {31'b0, mem_rd}, 0);
    chk("rst_memwr", {31'b0, mem_wr}, 0);
    chk("rst_memdin", {31'b0, mem_din}, 0);
    chk("rst_memxy", {24'b0, mem_y, mem_x}, 0);
    chk("rst_busy", {31'b0, clr_busy}, 0);
    chk("rst_done", {31'b0, clr_done}, 0);
    rst = 1'b0;
    tick();

    // host write alone, then idle
    single("t1", 1'b0, 1'b1, 4'd3, 4'd5, 1'b1);
    tick();
    chk("t1_single", {30'b0, mem_rd, mem_wr}, 0);

    // solver read alone of a cell holding 1
    single("t2pre", 1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
    single("t2", 1'b1, 1'b0, 4'd15, 4'd15, 1'b0);

    // both requesting continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 4'd15, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
    push(1'b0, 1'b0, 4'd15, 4'd15, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
    last_ack = 0;
    for (int i = 0; i < 9; i++) begin
      wait_mem("t3", 3);
      chk_access("t3");
      tick();
      chk_resp("t3");
      if (i > 0) chk("t3_space", cyc - last_ack, 3);
      last_ack = cyc;
    end
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_rd | mem_wr | hst_ack | slv_ack) errs++;
    end
    chk("t3_quiet", errs, 0);

    // clear requested during a host access, solver waiting
    push(1'b0, 1'b1, 4'd4, 4'd4, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 4'd4, 4'd4, 1'b1);
    wait_mem("t4h", 1);
    chk_access("t4h");
    clr_start = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 1'b0);
    tick();
    clr_start = 1'b0;
    chk_resp("t4h");
    chk("t4_pend_busy", {31'b0, clr_busy}, 1);
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_mem("t4c", 3);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_din !== 1'b0 ||
          mem_x !== i[3:0] || mem_y !== i[7:4] ||
          clr_busy !== 1'b1 || clr_done !== 1'b0 ||
          hst_ack !== 1'b0 || slv_ack !== 1'b0) errs++;
      tick();
    end
    chk("t4_sweep", errs, 0);
    chk("t4_done", {31'b0, clr_done}, 1);
    chk("t4_idle_wr", {31'b0, mem_wr}, 0);
    chk("t4_busy_off", {31'b0, clr_busy}, 0);
    for (int i = 0; i < 256; i++) sh_mem[i] = 1'b0;
    push(1'b1, 1'b0, 4'd4, 4'd4, 1'b0);
    tick();
    chk("t4_done_pulse", {31'b0, clr_done}, 0);
    chk_access("t4s");
    tick();
    chk_resp("t4s");
    drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    tick(); tick();

    // reset in the middle of a sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("t5_busy", {31'b0, clr_busy}, 1);
    chk("t5_c0", {24'b0, mem_y, mem_x}, 0);
    for (int i = 0; i < 100; i++) tick();
    chk("t5_c100", {24'b0, mem_y, mem_x}, 100);
    chk("t5_c100_wr", {31'b0, mem_wr}, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_wr", {31'b0, mem_wr}, 0);
    chk("t5_rst_busy", {31'b0, clr_busy}, 0);
    chk("t5_rst_done", {31'b0, clr_done}, 0);
    rst = 1'b0;
    for (int i = 0; i <= 100; i++) sh_mem[i] = 1'b0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_wr | mem_rd | clr_done | clr_busy) errs++;
    end
    chk("t5_no_resume", errs, 0);
    single("t5w", 1'b0, 1'b1, 4'd2, 4'd0, 1'b1);
    single("t5r", 1'b0, 1'b0, 4'd2, 4'd0, 1'b0);

    // host drops request right after capture
    push(1'b0, 1'b1, 4'd10, 4'd10, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 4'd10, 4'd10, 1'b1);
    tick();
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk_access("t6");
    tick();
    chk_resp("t6");
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_wr | mem_rd | hst_ack | slv_ack) errs++;
    end
    chk("t6_once", errs, 0);
    single("t6r", 1'b1, 1'b0, 4'd10, 4'd10, 1'b0);
    chk("q_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
